// File: rtl/l1icache_nway_pkg.sv
// Shared types for the L1 instruction cache: cache line, bus id width and FSM states.
package l1icache_nway_pkg;
  localparam int LINE_BITS = 64;
  localparam int ID_BITS   = 4;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [2:0] {
    SWEEP,
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    REPLAY
  } icache_state_e;
endpackage

// File: rtl/l1icache_nway_if.sv
// Fetch-side and memory-side handshake bundles for the L1 instruction cache.
interface l1icache_core_if #(
  parameter int ADDR_BITS = 28
);
  import l1icache_nway_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 resp_valid;
  line_t                resp_data;

  modport Server (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
  modport Client (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
endinterface

interface l1cache_mem_if #(
  parameter int ADDR_BITS = 28
);
  import l1icache_nway_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_we;
  logic [ID_BITS-1:0]   req_id;
  line_t                req_data;
  logic                 resp_valid;
  logic                 resp_ready;
  line_t                resp_data;

  modport Client (output req_valid, req_addr, req_we, req_id, req_data, resp_ready,
                  input  req_ready, resp_valid, resp_data);
  modport Server (input  req_valid, req_addr, req_we, req_id, req_data, resp_ready,
                  output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/l1icache_nway_plru_tree.sv
// Combinational tree-PLRU: heap-ordered node bits, 0 = victim on the left subtree.
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         bits_i,
  input  logic [$clog2(WAYS)-1:0] access_way_i,
  output logic [WAYS-2:0]         bits_o,
  output logic [$clog2(WAYS)-1:0] victim_o
);
  localparam int LEVELS = $clog2(WAYS);

  int   node_upd;
  int   node_vic;
  logic dir_upd;
  logic dir_vic;

  always_comb begin
    bits_o   = bits_i;
    victim_o = '0;
    node_upd = 0;
    node_vic = 0;
    dir_upd  = 1'b0;
    dir_vic  = 1'b0;
    for (int l = 0; l < LEVELS; l++) begin
      // Each node on the accessed path is pointed at the sibling subtree.
      dir_upd = access_way_i[LEVELS-1-l];
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == node_upd) bits_o[n] = ~dir_upd;
      end
      node_upd = 2 * node_upd + 1 + int'(dir_upd);

      dir_vic = 1'b0;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == node_vic) dir_vic = bits_i[n];
      end
      victim_o[LEVELS-1-l] = dir_vic;
      node_vic = 2 * node_vic + 1 + int'(dir_vic);
    end
  end
endmodule

// File: rtl/l1icache_nway.sv
// N-way set-associative read-only L1 I-cache with tree-PLRU replacement and an
// invalidate-all sweep used after reset and for fence.i.
module l1icache_nway
  import l1icache_nway_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int SET_BITS  = 4,
  parameter int ADDR_BITS = 28
) (
  input  logic            clk,
  input  logic            rst,
  l1icache_core_if.Server core,
  l1cache_mem_if.Client   bus,
  input  logic            inv_valid,
  output logic            inv_ready
);
  localparam int SETS     = 2 ** SET_BITS;
  localparam int TAG_BITS = ADDR_BITS - SET_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [SET_BITS-1:0] set_t;
  typedef logic [WAY_BITS-1:0] way_t;
  typedef logic [WAYS-2:0]     plru_t;
  typedef struct packed {
    logic valid;
    tag_t tag;
  } meta_way_t;

  icache_state_e state_q, state_d;
  set_t      sweep_cnt_q, sweep_cnt_d;
  logic      inv_pend_q, inv_pend_d;
  logic      inv_ready_q, inv_ready_d;
  logic      s1_vld_q, s1_vld_d;
  tag_t      tag_q, tag_d;
  set_t      set_q, set_d;
  way_t      victim_q, victim_d;

  meta_way_t meta_mem [WAYS][SETS];
  line_t     data_mem [WAYS][SETS];
  meta_way_t meta_rd  [WAYS];
  line_t     data_rd  [WAYS];
  plru_t     plru_q   [SETS];

  set_t        ram_addr;
  logic        ram_re;
  logic [WAYS-1:0] meta_we, data_we;
  meta_way_t   meta_wdata;
  logic        plru_we;
  set_t        plru_set;
  plru_t       plru_wdata, plru_new;
  way_t        access_way, plru_victim;
  logic [WAYS-1:0] hit_vec;
  way_t        hit_way, inv_way;
  logic        any_inv, hit, miss, inv_take;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i      (plru_q[set_q]),
    .access_way_i(access_way),
    .bits_o      (plru_new),
    .victim_o    (plru_victim)
  );

  assign bus.req_addr   = {tag_q, set_q};
  assign bus.req_we     = 1'b0;
  assign bus.req_id     = '0;
  assign bus.req_data   = '0;
  assign bus.resp_ready = 1'b1;
  assign inv_ready      = inv_ready_q;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = meta_rd[w].valid && (meta_rd[w].tag == tag_q);
      if (hit_vec[w]) hit_way = way_t'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!meta_rd[w].valid) begin
        inv_way = way_t'(w);
        any_inv = 1'b1;
      end
    end
    hit      = (state_q == IDLE) && s1_vld_q && (|hit_vec);
    miss     = (state_q == IDLE) && s1_vld_q && !(|hit_vec);
    inv_take = inv_valid && !s1_vld_q && !inv_ready_q;
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    inv_pend_d  = inv_pend_q;
    inv_ready_d = 1'b0;
    s1_vld_d    = s1_vld_q;
    tag_d       = tag_q;
    set_d       = set_q;
    victim_d    = victim_q;
    ram_addr    = set_q;
    ram_re      = 1'b0;
    meta_we     = '0;
    data_we     = '0;
    meta_wdata  = {1'b1, tag_q};
    plru_we     = 1'b0;
    plru_set    = set_q;
    plru_wdata  = plru_new;
    access_way  = hit_way;
    core.req_ready  = 1'b0;
    core.resp_valid = 1'b0;
    core.resp_data  = data_rd[hit_way];
    bus.req_valid   = 1'b0;

    case (state_q)
      SWEEP: begin
        ram_addr    = sweep_cnt_q;
        meta_we     = '1;
        meta_wdata  = '0;
        plru_we     = 1'b1;
        plru_set    = sweep_cnt_q;
        plru_wdata  = '0;
        s1_vld_d    = 1'b0;
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == set_t'(SETS-1)) begin
          state_d     = IDLE;
          inv_ready_d = inv_pend_q;
          inv_pend_d  = 1'b0;
        end
      end
      IDLE: begin
        if (hit) begin
          core.resp_valid = 1'b1;
          plru_we         = 1'b1;
        end
        if (miss) begin
          state_d  = MISS_REQ;
          victim_d = any_inv ? inv_way : plru_victim;
        end else if (inv_take) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
          inv_pend_d  = 1'b1;
          s1_vld_d    = 1'b0;
        end else begin
          core.req_ready = 1'b1;
          s1_vld_d       = core.req_valid;
          if (core.req_valid) begin
            tag_d    = core.req_addr[ADDR_BITS-1:SET_BITS];
            set_d    = core.req_addr[SET_BITS-1:0];
            ram_addr = core.req_addr[SET_BITS-1:0];
            ram_re   = 1'b1;
          end
        end
      end
      MISS_REQ: begin
        bus.req_valid = 1'b1;
        if (!core.req_valid) s1_vld_d = 1'b0;
        if (bus.req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (!core.req_valid) s1_vld_d = 1'b0;
        if (bus.resp_valid) begin
          meta_we[victim_q] = 1'b1;
          data_we[victim_q] = 1'b1;
          plru_we           = 1'b1;
          access_way        = victim_q;
          state_d           = REPLAY;
        end
      end
      REPLAY: begin
        // Re-read the refilled set so the next IDLE cycle sees a guaranteed hit.
        ram_re  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
      inv_pend_q  <= 1'b0;
      inv_ready_q <= 1'b0;
      s1_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      inv_pend_q  <= inv_pend_d;
      inv_ready_q <= inv_ready_d;
      s1_vld_q    <= s1_vld_d;
    end
    tag_q    <= tag_d;
    set_q    <= set_d;
    victim_q <= victim_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[plru_set] <= plru_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!rst && meta_we[w]) meta_mem[w][ram_addr] <= meta_wdata;
      if (!rst && data_we[w]) data_mem[w][ram_addr] <= bus.resp_data;
      if (ram_re) begin
        meta_rd[w] <= meta_mem[w][ram_addr];
        data_rd[w] <= data_mem[w][ram_addr];
      end
    end
    if (!rst && state_q == IDLE && s1_vld_q) assert ($onehot0(hit_vec));
  end
endmodule

// File: tb/tb_l1icache_nway.sv
// Directed bench for l1icache_nway: reset sweep, cold miss, PLRU eviction,
// back-to-back hits, fence.i sweep and reset during an outstanding miss.
module tb_l1icache_nway;
  import l1icache_nway_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic inv_valid;
  logic inv_ready;

  l1icache_core_if #(.ADDR_BITS(28)) cif ();
  l1cache_mem_if   #(.ADDR_BITS(28)) mif ();

  l1icache_nway #(.WAYS(4), .SET_BITS(4), .ADDR_BITS(28)) dut (
    .clk      (clk),
    .rst      (rst),
    .core     (cif),
    .bus      (mif),
    .inv_valid(inv_valid),
    .inv_ready(inv_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int          bus_cnt = 0;
  logic [27:0] bus_last_addr = '0;
  int          bus_resp_cyc = 0;
  int          bus_dly = 0;
  bit          bus_pend = 0;
  logic [27:0] bus_pend_addr = '0;
  int          core_resp_cyc = 0;

  function automatic line_t mem_line(input logic [27:0] a);
    return {4'h5, a, 4'hA, a ^ 28'hBEEF123};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [27:0] a, output line_t d, output int lat, output bit got);
    int n;
    @(negedge clk);
    cif.req_valid = 1'b1;
    cif.req_addr  = a;
    n = 0;
    while (cif.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    got = 1'b0;
    d   = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cif.resp_valid === 1'b1) begin
        got = 1'b1;
        d   = cif.resp_data;
        core_resp_cyc = cyc;
      end
    end
    cif.req_valid = 1'b0;
  endtask

  // Memory model: accepts every request and answers three cycles later.
  initial begin
    mif.req_ready  = 1'b1;
    mif.resp_valid = 1'b0;
    mif.resp_data  = '0;
    forever begin
      @(negedge clk);
      mif.resp_valid = 1'b0;
      if (bus_pend) begin
        if (bus_dly == 1) begin
          mif.resp_valid = 1'b1;
          mif.resp_data  = mem_line(bus_pend_addr);
          bus_resp_cyc   = cyc;
          bus_pend       = 1'b0;
        end else begin
          bus_dly--;
        end
      end
      if (mif.req_valid === 1'b1 && mif.req_ready) begin
        bus_cnt++;
        bus_last_addr = mif.req_addr;
        bus_pend      = 1'b1;
        bus_dly       = 3;
        bus_pend_addr = mif.req_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    line_t d;
    int    lat;
    bit    got;
    int    n;
    int    base;

    rst           = 1'b1;
    inv_valid     = 1'b0;
    cif.req_valid = 1'b0;
    cif.req_addr  = '0;

    // Reset and power-on sweep
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready",  cif.req_ready,  1'b0);
    check("rst_resp_valid", cif.resp_valid, 1'b0);
    check("rst_bus_valid",  mif.req_valid,  1'b0);
    check("rst_inv_ready",  inv_ready,      1'b0);
    check("bus_req_we",     mif.req_we,     1'b0);
    check("bus_req_id",     mif.req_id,     4'h0);
    check("bus_req_data",   mif.req_data,   64'h0);
    check("bus_resp_ready", mif.resp_ready, 1'b1);
    n = 0;
    while (cif.req_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rst_sweep_cycles", n, 16);

    // Cold miss then hit
    base = bus_cnt;
    fetch(28'h10, d, lat, got);
    check("cold_got",       got, 1'b1);
    check("cold_data",      d, mem_line(28'h10));
    check("cold_bus_cnt",   bus_cnt - base, 1);
    check("cold_bus_addr",  bus_last_addr, 28'h10);
    check("cold_resp_gap",  core_resp_cyc - bus_resp_cyc, 2);
    fetch(28'h10, d, lat, got);
    check("rehit_lat",      lat, 1);
    check("rehit_data",     d, mem_line(28'h10));
    check("rehit_no_bus",   bus_cnt - base, 1);

    // Fill set 0 past capacity; PLRU must pick 0x20 as the victim for 0x50
    fetch(28'h20, d, lat, got);
    check("fill20_data", d, mem_line(28'h20));
    fetch(28'h10, d, lat, got);
    check("hit10_a_lat", lat, 1);
    fetch(28'h30, d, lat, got);
    check("fill30_data", d, mem_line(28'h30));
    fetch(28'h10, d, lat, got);
    check("hit10_b_lat", lat, 1);
    fetch(28'h40, d, lat, got);
    check("fill40_data", d, mem_line(28'h40));
    base = bus_cnt;
    fetch(28'h50, d, lat, got);
    check("fill50_data",  d, mem_line(28'h50));
    check("fill50_miss",  bus_cnt - base, 1);
    check("fill50_addr",  bus_last_addr, 28'h50);
    fetch(28'h10, d, lat, got);
    check("keep10_lat",   lat, 1);
    check("keep10_data",  d, mem_line(28'h10));
    fetch(28'h30, d, lat, got);
    check("keep30_lat",   lat, 1);
    fetch(28'h40, d, lat, got);
    check("keep40_lat",   lat, 1);
    fetch(28'h50, d, lat, got);
    check("keep50_lat",   lat, 1);
    base = bus_cnt;
    fetch(28'h20, d, lat, got);
    check("evict20_miss", bus_cnt - base, 1);
    check("evict20_data", d, mem_line(28'h20));

    // Back-to-back hits on eight resident lines in sets 1..8
    for (int a = 1; a <= 8; a++) fetch(28'(a), d, lat, got);
    base = bus_cnt;
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        check($sformatf("b2b_valid_%0d", k), cif.resp_valid, 1'b1);
        check($sformatf("b2b_data_%0d", k),  cif.resp_data, mem_line(28'(k)));
      end
      if (k < 8) begin
        cif.req_valid = 1'b1;
        cif.req_addr  = 28'(k + 1);
        @(negedge clk);
      end else begin
        cif.req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_tail_idle", cif.resp_valid, 1'b0);
    check("b2b_no_bus",    bus_cnt - base, 0);

    // fence.i invalidate-all
    fetch(28'h10, d, lat, got);
    check("warm10_lat", lat, 1);
    @(negedge clk);
    inv_valid = 1'b1;
    n = 0;
    while (inv_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    inv_valid = 1'b0;
    check("inv_latency", n, 17);
    @(negedge clk);
    check("inv_ready_pulse", inv_ready, 1'b0);
    base = bus_cnt;
    fetch(28'h10, d, lat, got);
    check("postinv_miss",  bus_cnt - base, 1);
    check("postinv_addr",  bus_last_addr, 28'h10);
    check("postinv_data",  d, mem_line(28'h10));

    // Reset while waiting for a refill; the late response must be dropped
    base = bus_cnt;
    @(negedge clk);
    cif.req_valid = 1'b1;
    cif.req_addr  = 28'h60;
    n = 0;
    while (mif.req_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rmm_bus_req_seen", mif.req_valid, 1'b1);
    @(negedge clk);
    rst           = 1'b1;
    cif.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (cif.req_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rmm_sweep_cycles", n, 16);
    check("rmm_resp_quiet",   cif.resp_valid, 1'b0);
    check("rmm_one_bus_req",  bus_cnt - base, 1);
    base = bus_cnt;
    fetch(28'h60, d, lat, got);
    check("rmm_60_miss",  bus_cnt - base, 1);
    check("rmm_60_data",  d, mem_line(28'h60));
    fetch(28'h10, d, lat, got);
    check("rmm_10_miss",  bus_cnt - base, 2);
    fetch(28'h01, d, lat, got);
    check("rmm_01_miss",  bus_cnt - base, 3);
    check("rmm_01_data",  d, mem_line(28'h01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
